seg_bcd_capture: RTL and testbench

SEG_BCD_CAPTURE -- requirements
Module: seg_bcd_capture

---
 rtl/seg_bcd_pkg.sv | 41 ++++
 rtl/seg_pattern_decode.sv | 36 +++
 rtl/seg_bcd_capture.sv | 128 ++++++++++++
 tb/tb_seg_bcd_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_bcd_pkg.sv
// Shared constants and types for the multiplexed
// seven-segment display capture block.
package seg_bcd_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] PAT_0 = 7'b1111110;
  localparam logic [6:0] PAT_1 = 7'b0110000;
  localparam logic [6:0] PAT_2 = 7'b1101101;
  localparam logic [6:0] PAT_3 = 7'b1111001;
  localparam logic [6:0] PAT_4 = 7'b0110011;
  localparam logic [6:0] PAT_5 = 7'b1011011;
  localparam logic [6:0] PAT_6 = 7'b1011111;
  localparam logic [6:0] PAT_7 = 7'b1110000;
  localparam logic [6:0] PAT_8 = 7'b1111111;
  localparam logic [6:0] PAT_9 = 7'b1111011;

  localparam logic [6:0] PAT_BLANK = 7'b0000000;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] sel;
  } sample_t;

  function automatic logic is_onehot4(
    input logic [3:0] v
  );
    return (v != 4'd0) &&
           ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to BCD
// decoder with blank and error classification.
module seg_pattern_decode
  import seg_bcd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = ERR_CODE;
    err  = 1'b1;
    unique case (seg)
      PAT_0: begin code = 4'd0; err = 1'b0; end
      PAT_1: begin code = 4'd1; err = 1'b0; end
      PAT_2: begin code = 4'd2; err = 1'b0; end
      PAT_3: begin code = 4'd3; err = 1'b0; end
      PAT_4: begin code = 4'd4; err = 1'b0; end
      PAT_5: begin code = 4'd5; err = 1'b0; end
      PAT_6: begin code = 4'd6; err = 1'b0; end
      PAT_7: begin code = 4'd7; err = 1'b0; end
      PAT_8: begin code = 4'd8; err = 1'b0; end
      PAT_9: begin code = 4'd9; err = 1'b0; end
      PAT_BLANK: begin
        code = BLANK_CODE;
        err  = 1'b0;
      end
      default: begin
        code = ERR_CODE;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_bcd_capture.sv
// Debounces a multiplexed 4-digit seven-segment bus
// and emits whole decoded frames with a valid/ready handshake.
module seg_bcd_capture
  import seg_bcd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] out_bcd,
  output logic [3:0]  out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [3:0] CNT_PRE = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_MAX = 4'hF;

  sample_t     smp_d, smp_q;
  logic [3:0]  cnt_d, cnt_q;
  logic        capture;

  logic [3:0]  mask_d, mask_q;
  logic [15:0] stg_code_d, stg_code_q;
  logic [3:0]  stg_err_d, stg_err_q;
  logic        done_d, done_q;

  logic [15:0] bcd_d, bcd_q;
  logic [3:0]  oerr_d, oerr_q;
  logic        valid_d, valid_q;
  logic        ovr_d, ovr_q;

  logic [3:0]  dec_code;
  logic        dec_err;

  seg_pattern_decode u_dec (
    .seg  (smp_q.seg),
    .code (dec_code),
    .err  (dec_err)
  );

  // Capture fires on the single edge where the run
  // length reaches the target; saturation blocks repeats.
  always_comb begin
    smp_d   = '{seg: seg, sel: dig_sel};
    cnt_d   = 4'd0;
    capture = 1'b0;
    if (is_onehot4(smp_d.sel) &&
        (smp_d == smp_q)) begin
      cnt_d   = (cnt_q == CNT_MAX) ?
                cnt_q : cnt_q + 4'd1;
      capture = (cnt_q == CNT_PRE);
    end
  end

  always_comb begin
    mask_d     = mask_q;
    stg_code_d = stg_code_q;
    stg_err_d  = stg_err_q;
    done_d     = 1'b0;
    if (done_q) begin
      mask_d = 4'd0;
    end
    if (capture) begin
      mask_d = mask_q | smp_q.sel;
      done_d = ((mask_q | smp_q.sel) == 4'hF);
      for (int i = 0; i < 4; i++) begin
        if (smp_q.sel[i]) begin
          stg_code_d[4*i +: 4] = dec_code;
          stg_err_d[i]         = dec_err;
        end
      end
    end
  end

  always_comb begin
    bcd_d   = bcd_q;
    oerr_d  = oerr_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (done_q) begin
      if (!valid_q || out_ready) begin
        bcd_d   = stg_code_q;
        oerr_d  = stg_err_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q      <= '0;
      cnt_q      <= 4'd0;
      mask_q     <= 4'd0;
      stg_code_q <= {4{BLANK_CODE}};
      stg_err_q  <= 4'd0;
      done_q     <= 1'b0;
      bcd_q      <= {4{BLANK_CODE}};
      oerr_q     <= 4'd0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      smp_q      <= smp_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      stg_code_q <= stg_code_d;
      stg_err_q  <= stg_err_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      oerr_q     <= oerr_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_bcd   = bcd_q;
  assign out_err   = oerr_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg_bcd_capture.sv
// Self-checking bench: directed scenarios plus random
// traffic compared each cycle against a behavioural model.
module tb_seg_bcd_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] out_bcd;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  always #5 clk = ~clk;

  seg_bcd_capture #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  logic [6:0] PAT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011
  };

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void mdec(input logic [6:0] s,
                               output logic [3:0] c,
                               output logic e);
    c = 4'hE;
    e = 1'b1;
    if (s == 7'd0) begin
      c = 4'hF;
      e = 1'b0;
    end
    for (int k = 0; k < 10; k++)
      if (s == PAT[k]) begin
        c = 4'(k);
        e = 1'b0;
      end
  endfunction

  // Behavioural model: run length of identical samples,
  // digit table, pending frame and output handshake.
  logic [10:0] m_last;
  int          m_run;
  logic [3:0]  m_mask;
  logic [3:0]  m_code [4];
  logic        m_err  [4];
  bit          m_pend;
  logic [15:0] m_bcd;
  logic [3:0]  m_oerr;
  bit          m_valid;
  bit          m_ovr;

  always @(posedge clk) begin : model
    logic [10:0] v;
    logic [3:0]  c;
    logic        e;
    int          d;
    if (reset) begin
      m_last  = '0;
      m_run   = 0;
      m_mask  = 4'd0;
      for (int i = 0; i < 4; i++) begin
        m_code[i] = 4'hF;
        m_err[i]  = 1'b0;
      end
      m_pend  = 1'b0;
      m_bcd   = 16'hFFFF;
      m_oerr  = 4'd0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (m_pend) begin
        if (!m_valid || out_ready) begin
          for (int i = 0; i < 4; i++) begin
            m_bcd[4*i +: 4] = m_code[i];
            m_oerr[i]       = m_err[i];
          end
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        m_mask = 4'd0;
        m_pend = 1'b0;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      v = {seg, dig_sel};
      if (v == m_last) m_run++;
      else m_run = 1;
      m_last = v;
      if ($countones(dig_sel) == 1 && m_run == S + 1) begin
        d = 0;
        for (int i = 0; i < 4; i++)
          if (dig_sel[i]) d = i;
        mdec(seg, c, e);
        m_code[d] = c;
        m_err[d]  = e;
        m_mask[d] = 1'b1;
        if (m_mask == 4'hF) m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_bcd",   out_bcd,   m_bcd);
      check("model_err",   out_err,   m_oerr);
      check("model_valid", out_valid, m_valid);
      check("model_ovr",   overrun,   m_ovr);
    end
  end

  task automatic hold(input logic [6:0] s,
                      input logic [3:0] d,
                      input int n);
    seg     = s;
    dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int pos, input int val);
    hold(PAT[val], 4'(1 << pos), 6);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    seg   = 7'd0;
    dig_sel = 4'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    seg       = 7'd0;
    dig_sel   = 4'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_bcd",   out_bcd,   16'hFFFF);
    check("rst_err",   out_err,   4'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ovr",   overrun,   1'b0);
    reset = 1'b0;

    // stable digit: capture at cycle S+1, frame one later
    digit(1, 1); digit(2, 1); digit(3, 1);
    hold(PAT[2], 4'b0001, 5);
    check("stab_c5_valid", out_valid, 1'b0);
    hold(PAT[2], 4'b0001, 1);
    check("stab_c6_valid", out_valid, 1'b1);
    check("stab_bcd", out_bcd, 16'h1112);
    hold(PAT[2], 4'b0001, 4);
    digit(1, 3); digit(2, 3); digit(3, 3);
    check("stab_no_recap", out_valid, 1'b0);
    do_reset();

    // full frame 3,0,7,9
    digit(0, 3); digit(1, 0); digit(2, 7); digit(3, 9);
    check("frame_valid", out_valid, 1'b1);
    check("frame_bcd",   out_bcd,   16'h9703);
    check("frame_err",   out_err,   4'd0);
    hold(7'd0, 4'd0, 1);
    check("frame_valid_1cyc", out_valid, 1'b0);
    do_reset();

    // glitching digit1 must never capture
    for (int i = 0; i < 6; i++)
      hold(PAT[i[0] ? 2 : 1], 4'b0010, 2);
    digit(0, 6); digit(2, 6); digit(3, 6);
    check("glitch_nocap", out_valid, 1'b0);
    digit(1, 5);
    check("glitch_valid", out_valid, 1'b1);
    check("glitch_bcd",   out_bcd,   16'h6656);

    // bad and blank patterns
    digit(0, 1);
    hold(7'b1000000, 4'b0010, 6);
    hold(7'b0000000, 4'b0100, 6);
    digit(3, 4);
    check("bad_valid", out_valid, 1'b1);
    check("bad_err",   out_err,   4'b0010);
    check("bad_bcd",   out_bcd,   16'h4FE1);
    hold(7'd0, 4'd0, 1);

    // backpressure across two completions
    out_ready = 1'b0;
    digit(0, 1); digit(1, 2); digit(2, 3); digit(3, 4);
    check("bp_valid_a", out_valid, 1'b1);
    check("bp_bcd_a",   out_bcd,   16'h4321);
    check("bp_ovr_a",   overrun,   1'b0);
    digit(0, 5); digit(1, 6); digit(2, 7); digit(3, 8);
    check("bp_bcd_b",   out_bcd,   16'h4321);
    check("bp_ovr_b",   overrun,   1'b1);
    out_ready = 1'b1;
    hold(7'd0, 4'd0, 1);
    check("bp_drop",    out_valid, 1'b0);
    check("bp_ovr_sticky", overrun, 1'b1);

    // reset abandons a partial frame
    digit(0, 9); digit(1, 9);
    do_reset();
    check("mid_rst_ovr", overrun,   1'b0);
    check("mid_rst_bcd", out_bcd,   16'hFFFF);
    digit(2, 8); digit(3, 0);
    check("mid_no_early", out_valid, 1'b0);
    digit(0, 2); digit(1, 5);
    check("mid_valid", out_valid, 1'b1);
    check("mid_bcd",   out_bcd,   16'h0852);
    hold(PAT[7], 4'b0011, 10);
    digit(1, 1); digit(2, 1); digit(3, 1);
    check("multi_sel_nocap", out_valid, 1'b0);
    do_reset();

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [3:0] d;
      logic [6:0] s;
      r = $urandom_range(0, 9);
      if (r < 8)       d = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) d = 4'd0;
      else             d = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 11);
      if (r < 10)       s = PAT[r];
      else if (r == 10) s = 7'd0;
      else              s = 7'($urandom_range(0, 127));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) do_reset();
      else hold(s, d, $urandom_range(1, 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
